// File: rtl/vram_arb_pkg.sv
// Package: vram_arb_pkg
// Shared constants and types for the VRAM access arbiter.
//  - Raster geometry of the 1280x720@60 timing (1650x750 total).
//  - Arbiter state encoding: plain localparam constants, with an enum
//    type built on top of them.
//  - next_ptr: round-robin pointer advance with wrap at NREQ-1.
package vram_arb_pkg;

  localparam int H_ACT = 1280;
  localparam int H_TOT = 1650;
  localparam int V_ACT = 720;
  localparam int V_TOT = 750;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DISP  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DISP  = ST_DISP,
    SERVE = ST_SERVE
  } arb_state_e;

  // Index after idx, wrapping from nreq-1 back to 0.
  function automatic int next_ptr(input int idx, input int nreq);
    return (idx >= nreq - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vram_access_arbiter_rr_picker.sv
// Module: rr_picker
// Combinational round-robin priority encoder. Picks the first set bit of
// req at or after ptr, wrapping from NREQ-1 to 0.
// Ports:
//  req      in   NREQ    candidate requests
//  ptr      in   PTR_W   highest-priority index this cycle
//  win      out  NREQ    one-hot winner (all zero when req is zero)
//  win_idx  out  PTR_W   binary index of the winner
//  found    out  1       a winner exists
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] win_idx,
  output logic             found
);

  always_comb begin
    int idx;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[PTR_W'(idx)]) begin
        win[PTR_W'(idx)] = 1'b1;
        win_idx          = PTR_W'(idx);
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_access_arbiter.sv
// Module: vram_access_arbiter
// Shares one single-port frame-buffer RAM between the display fetch path and
// NREQ requesters. The display owns the RAM inside its fetch window (opens
// FETCH_LEAD cycles ahead of active video); outside it, requesters are served
// round-robin, one word per cycle.
//
// Optional build macro: VRAM_ARB_STARVE_EN adds the starve output and an
// 8-bit per-requester wait counter.
//
// Ports:
//  pclk, rst       pixel clock, asynchronous active-high reset
//  hcount, vcount  raster position (out-of-range values count as blanking)
//  disp_addr       display fetch address; disp_data returns 2 cycles later
//  req/req_we      per-requester request and write flag
//  req_addr/wdata  packed per-requester address / write data
//  gnt             registered one-hot grant pulse, issued with the RAM access
//  rd_valid        one-hot read return pulse, 2 cycles after gnt
//  rd_data         requester read data, qualified by rd_valid
//  mem_*           registered RAM port; mem_rdata arrives 1 cycle after mem_en
//  starve          (VRAM_ARB_STARVE_EN only) wait counter saturated at 255
//
// state | meaning
// IDLE  | no access issued this cycle
// DISP  | display fetch window: RAM read at disp_addr
// SERVE | outside the window with a pending request: one grant issued
module vram_access_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 12,
  parameter int FETCH_LEAD = 2
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [10:0]              hcount,
  input  logic [10:0]              vcount,
  input  logic [ADDR_W-1:0]        disp_addr,
  output logic [DATA_W-1:0]        disp_data,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
`ifdef VRAM_ARB_STARVE_EN
  output logic [NREQ-1:0]          starve,
`endif
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [10:0] H_FETCH_END   = 11'(H_ACT - FETCH_LEAD);
  localparam logic [10:0] H_FETCH_START = 11'(H_TOT - FETCH_LEAD);
  localparam logic [10:0] H_LIMIT       = 11'(H_TOT);
  localparam logic [10:0] V_ACT_L       = 11'(V_ACT);
  localparam logic [10:0] V_ACT_LAST    = 11'(V_ACT - 1);
  localparam logic [10:0] V_LAST        = 11'(V_TOT - 1);

  logic              line_act;
  logic              next_act;
  logic              disp_win;
  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   win_oh;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [NREQ-1:0]   rd_pend;
  logic              disp_rd;

  // Line 749 is blanking but precedes line 0, so it carries the lead part of
  // line 0's fetch window. Out-of-range vcount matches neither term.
  always_comb begin
    line_act = (vcount < V_ACT_L);
    next_act = (vcount < V_ACT_LAST) || (vcount == V_LAST);
    disp_win = (line_act && (hcount < H_FETCH_END)) ||
               (next_act && (hcount >= H_FETCH_START) && (hcount < H_LIMIT));
  end

  always_comb begin
    if (disp_win)  state_nxt = DISP;
    else if (|req) state_nxt = SERVE;
    else           state_nxt = IDLE;
  end

  // The requester currently seeing gnt still has req up this cycle (it only
  // reacts at the next edge), so it is masked out to avoid a double grant.
  assign elig = req & ~gnt;

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req     (elig),
    .ptr     (rr_ptr),
    .win     (win_oh),
    .win_idx (win_idx),
    .found   (win_found)
  );

  assign ptr_inc = PTR_W'(next_ptr(int'(win_idx), NREQ));

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pend   <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      disp_rd   <= 1'b0;
      disp_data <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state_nxt)
        DISP: begin
          mem_en   <= 1'b1;
          mem_addr <= disp_addr;
        end
        SERVE: begin
          if (win_found) begin
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            gnt       <= win_oh;
            rr_ptr    <= ptr_inc;
          end
        end
        default: ;
      endcase

      // Return pipeline: stage 1 tracks the cycle the RAM performs the read,
      // stage 2 captures mem_rdata.
      rd_pend  <= gnt & {NREQ{~mem_we}};
      rd_valid <= rd_pend;
      if (|rd_pend) rd_data <= mem_rdata;

      disp_rd <= (state == DISP);
      if (disp_rd) disp_data <= mem_rdata;
    end
  end

`ifdef VRAM_ARB_STARVE_EN
  logic [7:0] wait_cnt [NREQ];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || gnt[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != 8'hFF)
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < NREQ; i++) starve[i] = (wait_cnt[i] == 8'hFF);
  end
`else
  // No starvation tracking in this build.
`endif

endmodule

// File: tb/tb_vram_access_arbiter.sv
module tb_vram_access_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 12;

  logic                   pclk = 1'b0;
  logic                   rst;
  logic [10:0]            hcount;
  logic [10:0]            vcount;
  logic [ADDR_W-1:0]      disp_addr;
  logic [DATA_W-1:0]      disp_data;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata = '0;
`ifdef VRAM_ARB_STARVE_EN
  logic [NREQ-1:0]        starve;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  vram_access_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FETCH_LEAD(2)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef VRAM_ARB_STARVE_EN
    .starve    (starve),
`endif
    .mem_rdata (mem_rdata)
  );

  always #5 pclk = ~pclk;

  function automatic logic [11:0] ram_init(input int a);
    return 12'(a * 7 + 3);
  endfunction

  function automatic logic [17:0] a_of(input int h);
    return 18'(h * 3 + 7);
  endfunction

  // Fetch window for FETCH_LEAD=2: columns 0..1277 of active lines and
  // 1648..1649 of the line before an active line (749 precedes line 0).
  function automatic bit win(input int h, input int v);
    bit la, na;
    la = (v < 720);
    na = (v < 719) || (v == 749);
    return (la && h < 1278) || (na && h >= 1648 && h < 1650);
  endfunction

  // Synchronous single-port RAM: read data one cycle after mem_en.
  logic [DATA_W-1:0] ram [0:262143];
  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = ram_init(i);
    forever begin
      @(posedge pclk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},       32'(gnt),       32'h0);
    check({tag, " rd_valid"},  32'(rd_valid),  32'h0);
    check({tag, " mem_en"},    32'(mem_en),    32'h0);
    check({tag, " mem_we"},    32'(mem_we),    32'h0);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, " disp_data"}, 32'(disp_data), 32'h0);
    check({tag, " rd_data"},   32'(rd_data),   32'h0);
  endtask

  initial begin
    int h, hp1, hp2;
    int bh [10];
    int bv [10];
    bit bw [10];
    logic [2:0] exp_g [6];

    bh = '{1278, 1277, 1647, 1648, 1648,  100, 1700,  100, 1649,   0};
    bv = '{ 100,  100,  100,  719,  749,  749,  100,  760,  749, 720};
    bw = '{   0,    1,    0,    0,    1,    0,    0,    0,    1,   0};
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    rst       = 1'b1;
    hcount    = 11'd0;
    vcount    = 11'd730;
    disp_addr = '0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // 1: display fetch over one full line plus wrap
    vcount = 11'd100;
    hp1 = -1;
    hp2 = -1;
    for (int k = 0; k < 1652; k++) begin
      h = k % 1650;
      hcount    = 11'(h);
      disp_addr = a_of(h);
      tick();
      check("disp mem_en", 32'(mem_en), 32'(win(h, 100)));
      check("disp mem_we", 32'(mem_we), 32'h0);
      if (win(h, 100)) check("disp mem_addr", 32'(mem_addr), 32'(a_of(h)));
      if (hp2 >= 0 && win(hp2, 100))
        check("disp_data", 32'(disp_data), 32'(ram_init(int'(a_of(hp2)))));
      hp2 = hp1;
      hp1 = h;
    end

    // window boundaries and out-of-range raster positions
    for (int i = 0; i < 10; i++) begin
      hcount = 11'(bh[i]);
      vcount = 11'(bv[i]);
      tick();
      check("window edge mem_en", 32'(mem_en), 32'(bw[i]));
    end

    // 2: saturated round-robin writes in vblank
    vcount    = 11'd730;
    hcount    = 11'd100;
    req_we    = 3'b111;
    req_addr  = {18'h202, 18'h201, 18'h200};
    req_wdata = {12'h333, 12'h222, 12'h111};
    req       = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr gnt", 32'(gnt), 32'(exp_g[i]));
      check("rr mem_we", 32'(mem_we), 32'h1);
      check("rr mem_addr", 32'(mem_addr), 32'h200 + 32'(i % 3));
      check("rr no rd_valid", 32'(rd_valid), 32'h0);
    end
    req = 3'b000;
    tick();
    tick();
    check("rr idle gnt", 32'(gnt), 32'h0);
    check("rr write rd_valid", 32'(rd_valid), 32'h0);

    // 3: request held across the end of active video; req[1] stays up so it
    //    re-requests every other cycle after each grant
    vcount    = 11'd50;
    req_we    = 3'b010;
    req_addr  = {18'h0, 18'h300, 18'h0};
    req_wdata = {12'h0, 12'h5A5, 12'h0};
    req       = 3'b010;
    for (int hh = 1270; hh < 1650; hh++) begin
      hcount = 11'(hh);
      tick();
      if (hh >= 1278 && hh < 1648 && (hh % 2) == 0)
        check("preempt gnt", 32'(gnt), 32'h2);
      else
        check("preempt gnt", 32'(gnt), 32'h0);
    end
    req = 3'b000;
    tick();

    // 4: write then read back through requester 2
    vcount    = 11'd730;
    hcount    = 11'd100;
    req_addr  = {18'h100, 18'h0, 18'h0};
    req_wdata = {12'hABC, 12'h0, 12'h0};
    req_we    = 3'b100;
    req       = 3'b100;
    tick();
    check("wr gnt", 32'(gnt), 32'h4);
    check("wr mem_we", 32'(mem_we), 32'h1);
    check("wr mem_addr", 32'(mem_addr), 32'h100);
    check("wr mem_wdata", 32'(mem_wdata), 32'hABC);
    req = 3'b000;
    tick();
    check("wr gnt pulse", 32'(gnt), 32'h0);
    req_we = 3'b000;
    req    = 3'b100;
    tick();
    check("rd gnt", 32'(gnt), 32'h4);
    check("rd mem_we", 32'(mem_we), 32'h0);
    req = 3'b000;
    tick();
    check("rd_valid +1", 32'(rd_valid), 32'h0);
    tick();
    check("rd_valid +2", 32'(rd_valid), 32'h4);
    check("rd_data", 32'(rd_data), 32'hABC);
    tick();
    check("rd_valid pulse", 32'(rd_valid), 32'h0);

    // 5: reset while a read is in flight
    req_addr = {18'h0, 18'h100, 18'h0};
    req_we   = 3'b000;
    req      = 3'b010;
    tick();
    check("pre-reset gnt", 32'(gnt), 32'h2);
    req = 3'b000;
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("mid reset");
    tick();
    tick();
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("discarded rd_valid", 32'(rd_valid), 32'h0);
    end
    req_we = 3'b111;
    req    = 3'b111;
    tick();
    check("post-reset gnt", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();

`ifdef VRAM_ARB_STARVE_EN
    // 6: starvation through active video
    vcount = 11'd200;
    req_we = 3'b000;
    req    = 3'b001;
    for (int k = 1; k <= 300; k++) begin
      hcount = 11'(k - 1);
      tick();
      check("starve", 32'(starve), (k >= 255) ? 32'h1 : 32'h0);
    end
    hcount = 11'd1278;
    tick();
    check("starve gnt", 32'(gnt), 32'h1);
    check("starve at gnt", 32'(starve), 32'h1);
    req = 3'b000;
    tick();
    check("starve cleared", 32'(starve), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
